// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Purpose  : Two-port (A preferred, B starvation-bounded) sequencer for the
//            shared byte-addressed 16-bit data memory.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [1:0]        mode_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [1:0]        mode_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              err,
  output logic              busy,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [1:0]        mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_RESP  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]          r_state;
  logic [c_WAIT_W-1:0] r_wait_cnt;
  logic                r_sel_b;
  logic                r_we;
  logic [1:0]          r_mode;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata_a;
  logic [DATA_W-1:0]   r_rdata_b;

  logic                w_idle;
  logic                w_issue;
  logic                w_resp;
  logic                w_done;
  logic                w_gnt_a;
  logic                w_gnt_b;
  logic                w_mode_err;
  logic [DATA_W-1:0]   w_resp_data;

  assign w_idle     = (r_state == c_IDLE);
  assign w_issue    = (r_state == c_ISSUE);
  assign w_resp     = (r_state == c_RESP);
  assign w_done     = (r_state == c_DONE);
  assign w_mode_err = (r_mode == 2'b11);

  // B overrides A only once it has lost MAX_WAIT contested grants in a row
  assign w_gnt_b = w_idle && req_b && (!req_a || (r_wait_cnt == c_WAIT_MAX));
  assign w_gnt_a = w_idle && req_a && !w_gnt_b;

  assign w_resp_data = w_mode_err ? '0 : mem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= c_IDLE;
      r_wait_cnt <= '0;
      r_sel_b    <= 1'b0;
      r_we       <= 1'b0;
      r_mode     <= 2'b00;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_gnt_b) begin
            r_sel_b    <= 1'b1;
            r_we       <= we_b;
            r_mode     <= mode_b;
            r_addr     <= addr_b;
            r_wdata    <= wdata_b;
            r_wait_cnt <= '0;
            r_state    <= c_ISSUE;
          end else if (w_gnt_a) begin
            r_sel_b    <= 1'b0;
            r_we       <= we_a;
            r_mode     <= mode_a;
            r_addr     <= addr_a;
            r_wdata    <= wdata_a;
            if (req_b && (r_wait_cnt != c_WAIT_MAX)) begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            r_state    <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          // Reserved mode always takes the read-response path to report err
          r_state <= (r_we && !w_mode_err) ? c_DONE : c_RESP;
        end
        c_RESP: begin
          if (r_sel_b) begin
            r_rdata_b <= w_resp_data;
          end else begin
            r_rdata_a <= w_resp_data;
          end
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign gnt_a    = w_gnt_a;
  assign gnt_b    = w_gnt_b;
  assign busy     = !w_idle;
  assign rvalid_a = (w_resp || w_done) && !r_sel_b;
  assign rvalid_b = (w_resp || w_done) && r_sel_b;
  assign err      = w_resp && w_mode_err;

  // Memory output is registered, so it is only valid during RESP; forward it then
  assign rdata_a  = (w_resp && !r_sel_b) ? w_resp_data : r_rdata_a;
  assign rdata_b  = (w_resp && r_sel_b)  ? w_resp_data : r_rdata_b;

  assign mem_wr_en = w_issue && r_we && !w_mode_err;
  assign mem_rd_en = w_issue && !r_we && !w_mode_err;
  assign mem_mode  = r_mode;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Purpose  : Directed self-checking bench for data_mem_arbiter with a simple
//            byte-array data memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_a, we_a, req_b, we_b;
  logic [1:0]  mode_a, mode_b;
  logic [15:0] addr_a, wdata_a, addr_b, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b, err, busy;
  logic [15:0] rdata_a, rdata_b;
  logic        mem_wr_en, mem_rd_en;
  logic [1:0]  mem_mode;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0000;

  logic [7:0]  mem [0:65535];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MAX_WAIT(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .we_a(we_a), .mode_a(mode_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .mode_b(mode_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
    .rdata_a(rdata_a), .rdata_b(rdata_b), .err(err), .busy(busy),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory: full-word little-endian writes, registered reads with extension
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr]         <= mem_wdata[7:0];
      mem[mem_addr + 16'd1] <= mem_wdata[15:8];
    end
    if (mem_rd_en) begin
      case (mem_mode)
        2'b00:   mem_rdata <= {mem[mem_addr + 16'd1], mem[mem_addr]};
        2'b01:   mem_rdata <= {8'h00, mem[mem_addr]};
        2'b10:   mem_rdata <= {{8{mem[mem_addr][7]}}, mem[mem_addr]};
        default: mem_rdata <= 16'h0000;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access: grant, ISSUE, RESP/DONE, back to IDLE
  task automatic do_access(input logic pb, input logic we, input logic [1:0] mode,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp_rd, input logic exp_err);
    @(negedge clk);
    if (pb) begin
      req_b = 1'b1; we_b = we; mode_b = mode; addr_b = addr; wdata_b = wdata;
    end else begin
      req_a = 1'b1; we_a = we; mode_a = mode; addr_a = addr; wdata_a = wdata;
    end
    #1;
    chk("gnt_own",   pb ? gnt_b : gnt_a, 1);
    chk("gnt_other", pb ? gnt_a : gnt_b, 0);
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    chk("issue_rd_en", mem_rd_en, (!we && mode != 2'b11));
    chk("issue_wr_en", mem_wr_en, (we && mode != 2'b11));
    chk("issue_addr",  mem_addr, addr);
    chk("issue_busy",  busy, 1);
    if (we) chk("issue_wdata", mem_wdata, wdata);
    @(negedge clk);
    chk("rvalid_own",   pb ? rvalid_b : rvalid_a, 1);
    chk("rvalid_other", pb ? rvalid_a : rvalid_b, 0);
    chk("resp_err",     err, exp_err);
    if (!we) chk("resp_rdata", pb ? rdata_b : rdata_a, exp_rd);
    @(negedge clk);
    chk("rvalid_clear", pb ? rvalid_b : rvalid_a, 0);
    chk("idle_busy",    busy, 0);
    chk("idle_err",     err, 0);
    if (!we) chk("rdata_hold", pb ? rdata_b : rdata_a, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0002] = 8'h03;
    mem[16'h0003] = 8'h02;
    mem[16'h0020] = 8'h80;
    mem[16'hFFFF] = 8'h34;
    mem[16'h0000] = 8'h12;

    reset_n = 1'b0;
    req_a = 0; we_a = 0; mode_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; mode_b = 0; addr_b = 0; wdata_b = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_rvalid", {rvalid_a, rvalid_b, err}, 0);
    chk("rst_mem_en", {mem_wr_en, mem_rd_en}, 0);
    chk("rst_rdata",  {rdata_a, rdata_b}, 0);
    reset_n = 1'b1;

    // A word read at 0x0002, B sign/zero-extended bytes, A write then read back
    do_access(1'b0, 1'b0, 2'b00, 16'h0002, 16'h0000, 16'h0203, 1'b0);
    do_access(1'b1, 1'b0, 2'b10, 16'h0020, 16'h0000, 16'hFF80, 1'b0);
    do_access(1'b1, 1'b0, 2'b01, 16'h0020, 16'h0000, 16'h0080, 1'b0);
    do_access(1'b0, 1'b1, 2'b00, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
    do_access(1'b0, 1'b0, 2'b00, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
    // Word read at the top address wraps to byte 0 inside the memory
    do_access(1'b0, 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'h1234, 1'b0);
    // Reserved mode from B: no enables, zero data, err pulse
    do_access(1'b1, 1'b0, 2'b11, 16'h0020, 16'h0000, 16'h0000, 1'b1);

    // Contention: A wins four times, then B, repeating
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; mode_a = 2'b00; addr_a = 16'h0002;
    req_b = 1'b1; we_b = 1'b0; mode_b = 2'b01; addr_b = 16'h0020;
    for (int g = 0; g < 10; g++) begin
      int t;
      t = 0;
      #1;
      while (!(gnt_a || gnt_b) && t < 8) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk("fair_timeout", (t < 8), 1);
      chk("fair_gnt_b", gnt_b, (g % 5 == 4));
      chk("fair_gnt_a", gnt_a, (g % 5 != 4));
      @(negedge clk);
    end
    req_a = 1'b0; req_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("fair_idle", busy, 0);

    // Requests while busy are ignored; a request dropped before grant does nothing
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b0; mode_a = 2'b00; addr_a = 16'h0002;
    #1 chk("busy_gnt_a", gnt_a, 1);
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b1; we_b = 1'b0; mode_b = 2'b00; addr_b = 16'h0020;
    #1 chk("busy_issue_gnt_b", gnt_b, 0);
    @(negedge clk);
    chk("busy_resp_gnt_b", gnt_b, 0);
    req_b = 1'b0;
    @(negedge clk);
    chk("drop_idle_busy", busy, 0);
    @(negedge clk);
    chk("drop_no_access", busy, 0);

    // Reset asserted during ISSUE of a write
    @(negedge clk);
    req_a = 1'b1; we_a = 1'b1; mode_a = 2'b00; addr_a = 16'h0040; wdata_a = 16'h1111;
    #1 chk("rstw_gnt_a", gnt_a, 1);
    @(negedge clk);
    req_a = 1'b0;
    chk("rstw_wr_en_pre", mem_wr_en, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rstw_wr_en", mem_wr_en, 0);
    chk("rstw_busy",  busy, 0);
    chk("rstw_rvalid", rvalid_a, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstw_out_ctl",   {gnt_a, gnt_b, rvalid_a, rvalid_b, err, busy, mem_wr_en, mem_rd_en}, 0);
    chk("rstw_out_mem",   {mem_mode, mem_addr}, 0);
    chk("rstw_out_wdata", mem_wdata, 0);
    chk("rstw_out_rdata", {rdata_a, rdata_b}, 0);
    do_access(1'b0, 1'b0, 2'b00, 16'h0040, 16'h0000, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
